sa_feeder: RTL and testbench
============================

# sa_feeder

- Operand sequencer that sits directly upstream of the N×N systolic MAC array.
- Holds one A tile (N rows × K) and one W tile (K × N) in local registers, loaded through a simple write port.
- On `start`, it streams column k of A and row k of W into the array's raw inputs for K cycles.
- It also generates the per-PE `en_mult`/`clr_mult`/`en_accum`/`clr_accum` windows, so every PE accumulates exactly K products, and it pulses `done` once all results are final.

## Interface
- `N`, default 2: array dimension; must match the array's `N`.
- `K_MAX`, default 16: maximum inner dimension buffered.
- `DW`, default 32: operand width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ld_valid`  in  1  write strobe for the tile buffers.
- `ld_sel`  in  1  0 = A buffer, 1 = W buffer.
- `ld_row`  in  $clog2(K_MAX)  row index: A uses 0..N-1, W uses 0..K_MAX-1.
- `ld_col`  in  $clog2(K_MAX)  column index: A uses 0..K_MAX-1, W uses 0..N-1.
- `ld_data`  in  DW  value written.
- `start`  in  1  single-cycle request to run one tile.
- `k_len`  in  $clog2(K_MAX)+1  inner dimension K, legal range 1..K_MAX; sampled with `start`.
- `a_raw`  out  [N-1:0][DW-1:0]  drives the array's `a_in_raw`.
- `w_raw`  out  [N-1:0][DW-1:0]  drives the array's `w_in_raw`.
- `en_mult`, `clr_mult`, `en_accum`, `clr_accum`  out  [N-1:0][N-1:0] each  per-PE controls.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse; `c_out` is final in this cycle.
- `err`  out  1  one-cycle pulse when a request is rejected.

## Operation
- **Buffers:** registers, reset to 0. A write with indices outside the legal range is dropped and pulses `err`. `ld_valid` while `busy` is dropped and pulses `err`.
- **FSM states:** IDLE, CLEAR, STREAM, DRAIN, DONE.
- **IDLE:**
  - `start` with 1 ≤ `k_len` ≤ K_MAX: latch K, go to CLEAR.
  - `start` with `k_len` = 0 or > K_MAX: stay in IDLE, pulse `err`.
  - `start` and `ld_valid` in the same cycle: the load is performed first, and start sees the updated buffer.
- **CLEAR** (1 cycle): `clr_mult` and `clr_accum` are all ones; all enables are 0. Reset the cycle counter `c` to 0.
- **STREAM** (K cycles, `c` = 0..K-1):
  - `a_raw[i]` = A[i][c], `w_raw[j]` = W[c][j].
  - No skew is applied here; the array's internal delay registers and PE forwarding provide it.
- **DRAIN** (`c` = K..K+2(N-1)): `a_raw`/`w_raw` = 0. `c` keeps counting.
- **Enable windows**, for every PE (i,j), in both STREAM and DRAIN:
  - `en_mult[i][j]` = (c ≥ i+j) && (c < i+j+K).
  - `en_accum[i][j]` = (c ≥ i+j+1) && (c < i+j+K+1).
  - Accumulation trails the multiply by one cycle because the product register has 1 cycle of latency.
- **DONE** (1 cycle): `done`=1, all enables 0, then go to IDLE.
- **Hold after DONE:** results stay in the array, because `clr_*` is only asserted in CLEAR.
- `start` while `busy` is ignored (no `err`).
- **Arithmetic:** none inside this block. Operands pass through unmodified, DW bits.

## Timing
- `start` is sampled at cycle s.
- CLEAR at s+1.
- STREAM at s+2 .. s+K+1.
- DRAIN at s+K+2 .. s+K+2N.
- `done` at s+K+2N+1; `busy` falls after this cycle.
- PE(i,j) first `en_mult` at s+2+i+j. Last `en_accum` is PE(N-1,N-1) at s+K+2N.
- Data outputs are registered: the `a_raw`/`w_raw` value for step c appears in the same cycle as `c`.
- **Reset** (asynchronous, any state, including mid-STREAM):
  - State goes to IDLE; buffers and `c` are cleared.
  - `a_raw` and `w_raw` = 0, all four control buses = 0.
  - `busy`, `done`, `err` = 0.
  - No `done` is produced for an aborted tile.
- Back-to-back: a new `start` is accepted at s+K+2N+2, the first IDLE cycle after `done`.

## Test plan
- N=2, A=[[1,2],[3,4]], W=[[5,6],[7,8]], K=2, start at s → `done` exactly at s+7; array `c_out` = [[19,22],[43,50]].
- K=1, A col0=[2,3], W row0=[4,5] → `done` at s+6; `c_out`=[[8,10],[12,15]]. `en_mult[1][1]` high only at s+4; `en_accum[1][1]` high only at s+5.
- K=K_MAX=16 with all ones in A and W → every `c_out` = 16. `busy` high for 21 cycles.
- `k_len`=0 and `k_len`=17 → `err` pulse, `busy` stays 0, no enables asserted. `ld_valid` during `busy` → `err`, and buffer contents are unchanged on the next run.
- Assert `rst` at s+3 mid-STREAM → all outputs 0 in the same cycle (asynchronous). After release, rerun the first scenario → correct `c_out` [[19,22],[43,50]] only after the buffers are reloaded.
- `start` at s+4 while `busy` → ignored: exactly one `done`, at s+7. Second `start` at s+8 → second `done` at s+15.

Source files
------------

// File: rtl/sa_feeder.sv
// sa_feeder: buffers one A/W tile and streams it into an NxN systolic MAC array with per-PE enable windows.
module sa_feeder #(
  parameter int N = 2,
  parameter int K_MAX = 16,
  parameter int DW = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_valid,
  input  logic                       ld_sel,
  input  logic [$clog2(K_MAX)-1:0]   ld_row,
  input  logic [$clog2(K_MAX)-1:0]   ld_col,
  input  logic [DW-1:0]              ld_data,
  input  logic                       start,
  input  logic [$clog2(K_MAX):0]     k_len,
  output logic [N-1:0][DW-1:0]       a_raw,
  output logic [N-1:0][DW-1:0]       w_raw,
  output logic [N-1:0][N-1:0]        en_mult,
  output logic [N-1:0][N-1:0]        clr_mult,
  output logic [N-1:0][N-1:0]        en_accum,
  output logic [N-1:0][N-1:0]        clr_accum,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int KW = $clog2(K_MAX);
  localparam int CW = $clog2(K_MAX + 2 * N + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;
  state_t state, nxt_state;
  logic [CW-1:0] c, nxt_c, kc;
  logic [KW:0] k;
  logic [DW-1:0] a_buf [N][K_MAX];
  logic [DW-1:0] w_buf [K_MAX][N];
  logic [N-1:0][DW-1:0] nxt_a, nxt_w;
  logic [N-1:0][N-1:0] nxt_em, nxt_ea;
  logic k_ok, ld_ok, ld_go, strm, win;
  assign k_ok = k_len != '0 && k_len <= (KW+1)'(K_MAX);
  assign ld_ok = ld_sel ? (32'(ld_row) < K_MAX && 32'(ld_col) < N)
                        : (32'(ld_row) < N && 32'(ld_col) < K_MAX);
  assign ld_go = ld_valid && ld_ok && !busy;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign kc = CW'(k);
  always_comb begin
    nxt_state = state;
    nxt_c = c;
    case (state)
      IDLE: nxt_state = start && k_ok ? CLEAR : IDLE;
      CLEAR: begin
        nxt_state = STREAM;
        nxt_c = '0;
      end
      STREAM: begin
        nxt_c = c + 1'b1;
        nxt_state = c == kc - 1'b1 ? DRAIN : STREAM;
      end
      DRAIN: begin
        nxt_c = c + 1'b1;
        nxt_state = c == kc + CW'(2 * N - 2) ? DONE : DRAIN;
      end
      default: nxt_state = IDLE;
    endcase
  end
  // Outputs are computed from the next state/count so they register into the same cycle as c.
  assign strm = nxt_state == STREAM;
  assign win = strm || nxt_state == DRAIN;
  always_comb begin
    nxt_a = '0;
    nxt_w = '0;
    nxt_em = '0;
    nxt_ea = '0;
    for (int i = 0; i < N; i++) begin
      nxt_a[i] = strm ? a_buf[i][nxt_c[KW-1:0]] : '0;
      nxt_w[i] = strm ? w_buf[nxt_c[KW-1:0]][i] : '0;
      for (int j = 0; j < N; j++) begin
        nxt_em[i][j] = win && nxt_c >= CW'(i + j) && nxt_c < CW'(i + j) + kc;
        nxt_ea[i][j] = win && nxt_c >= CW'(i + j + 1) && nxt_c < CW'(i + j + 1) + kc;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      c <= '0;
      k <= '0;
      a_raw <= '0;
      w_raw <= '0;
      en_mult <= '0;
      en_accum <= '0;
      clr_mult <= '0;
      clr_accum <= '0;
      err <= 1'b0;
    end else begin
      state <= nxt_state;
      c <= nxt_c;
      if (state == IDLE && start && k_ok) k <= k_len;
      a_raw <= nxt_a;
      w_raw <= nxt_w;
      en_mult <= nxt_em;
      en_accum <= nxt_ea;
      clr_mult <= nxt_state == CLEAR ? '1 : '0;
      clr_accum <= nxt_state == CLEAR ? '1 : '0;
      err <= (ld_valid && (busy || !ld_ok)) || (state == IDLE && start && !k_ok);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int x = 0; x < K_MAX; x++) begin
          a_buf[i][x] <= '0;
          w_buf[x][i] <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int x = 0; x < K_MAX; x++) begin
          if (ld_go && !ld_sel && 32'(ld_row) == i && 32'(ld_col) == x) a_buf[i][x] <= ld_data;
          if (ld_go && ld_sel && 32'(ld_row) == x && 32'(ld_col) == i) w_buf[x][i] <= ld_data;
        end
    end
  end
endmodule

// File: tb/tb_sa_feeder.sv
// tb_sa_feeder: directed checks of sa_feeder timing and, via a behavioural array model, of resulting c_out.
module tb_sa_feeder;
  logic clk, rst, ld_valid, ld_sel, start;
  logic [3:0] ld_row, ld_col;
  logic [31:0] ld_data;
  logic [4:0] k_len;
  logic [1:0][31:0] a_raw, w_raw;
  logic [1:0][1:0] en_mult, clr_mult, en_accum, clr_accum;
  logic busy, done, err;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, s_cyc = 0;
  int em11_n, em11_at, ea11_n, ea11_at, en_any;
  int prod [2][2];
  int acc [2][2];
  logic [31:0] ah [64][2];
  logic [31:0] wh [64][2];
  int d, b, dn, d1, d2;
  logic seen;

  sa_feeder #(.N(2), .K_MAX(16), .DW(32)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_row(ld_row),
    .ld_col(ld_col), .ld_data(ld_data), .start(start), .k_len(k_len),
    .a_raw(a_raw), .w_raw(w_raw), .en_mult(en_mult), .clr_mult(clr_mult),
    .en_accum(en_accum), .clr_accum(clr_accum), .busy(busy), .done(done), .err(err)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Array model: PE(i,j) multiplies stream step c-i-j; product register feeds the accumulator a cycle later.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ah[cyc % 64][i] = a_raw[i];
      wh[cyc % 64][i] = w_raw[i];
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        if (clr_mult[i][j]) prod[i][j] = 0;
        if (clr_accum[i][j]) acc[i][j] = 0;
        if (en_accum[i][j]) acc[i][j] = acc[i][j] + prod[i][j];
        if (en_mult[i][j])
          prod[i][j] = int'(ah[(cyc - i - j + 64) % 64][i] * wh[(cyc - i - j + 64) % 64][j]);
      end
    if (en_mult[1][1]) begin em11_n++; em11_at = cyc; end
    if (en_accum[1][1]) begin ea11_n++; ea11_at = cyc; end
    if (|en_mult || |en_accum) en_any++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ld(input logic s, input int r, input int cl, input int v);
    ld_valid = 1; ld_sel = s; ld_row = 4'(r); ld_col = 4'(cl); ld_data = 32'(v);
    tick;
    ld_valid = 0;
  endtask

  task automatic load_s1;
    ld(0, 0, 0, 1); ld(0, 0, 1, 2); ld(0, 1, 0, 3); ld(0, 1, 1, 4);
    ld(1, 0, 0, 5); ld(1, 0, 1, 6); ld(1, 1, 0, 7); ld(1, 1, 1, 8);
  endtask

  task automatic run(input int k, output int d_at, output int b_n);
    start = 1; k_len = 5'(k); s_cyc = cyc; em11_n = 0; ea11_n = 0;
    tick;
    start = 0; d_at = -1; b_n = 0;
    for (int n = 1; n <= 40; n++) begin
      if (busy) b_n++;
      if (done) begin d_at = n; break; end
      tick;
    end
    tick;
  endtask

  task automatic chk_c(input string tag, input int e00, input int e01, input int e10, input int e11);
    chk({tag, "_c00"}, 64'(acc[0][0]), 64'(e00));
    chk({tag, "_c01"}, 64'(acc[0][1]), 64'(e01));
    chk({tag, "_c10"}, 64'(acc[1][0]), 64'(e10));
    chk({tag, "_c11"}, 64'(acc[1][1]), 64'(e11));
  endtask

  initial begin
    rst = 1; ld_valid = 0; ld_sel = 0; ld_row = 0; ld_col = 0; ld_data = 0; start = 0; k_len = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_a", 64'(a_raw), 0);
    chk("rst_en", 64'({en_mult, en_accum, clr_mult, clr_accum}), 0);
    rst = 0;
    tick;

    load_s1;
    chk("ld_ok_err", 64'(err), 0);
    run(2, d, b);
    chk("s1_done_at", 64'(d), 7);
    chk("s1_busy_n", 64'(b), 7);
    chk_c("s1", 19, 22, 43, 50);

    ld(0, 2, 0, 9);
    chk("oor_a_err", 64'(err), 1);
    ld(1, 0, 2, 9);
    chk("oor_w_err", 64'(err), 1);
    tick;
    chk("oor_err_clr", 64'(err), 0);

    ld(0, 0, 0, 2); ld(0, 1, 0, 3); ld(1, 0, 0, 4); ld(1, 0, 1, 5);
    run(1, d, b);
    chk("k1_done_at", 64'(d), 6);
    chk("k1_em11_n", 64'(em11_n), 1);
    chk("k1_em11_at", 64'(em11_at - s_cyc), 4);
    chk("k1_ea11_n", 64'(ea11_n), 1);
    chk("k1_ea11_at", 64'(ea11_at - s_cyc), 5);
    chk_c("k1", 8, 10, 12, 15);

    for (int r = 0; r < 2; r++)
      for (int x = 0; x < 16; x++) begin
        ld(0, r, x, 1);
        ld(1, x, r, 1);
      end
    run(16, d, b);
    chk("k16_done_at", 64'(d), 21);
    chk("k16_busy_n", 64'(b), 21);
    chk_c("k16", 16, 16, 16, 16);

    en_any = 0;
    start = 1; k_len = 0;
    tick;
    start = 0;
    chk("k0_err", 64'(err), 1);
    chk("k0_busy", 64'(busy), 0);
    tick;
    chk("k0_err_clr", 64'(err), 0);
    start = 1; k_len = 17;
    tick;
    start = 0;
    chk("k17_err", 64'(err), 1);
    tick;
    chk("k17_busy", 64'(busy), 0);
    tick;
    chk("bad_k_no_en", 64'(en_any), 0);

    load_s1;
    start = 1; k_len = 2;
    tick;
    start = 0;
    tick;
    ld_valid = 1; ld_sel = 0; ld_row = 0; ld_col = 0; ld_data = 99;
    tick;
    ld_valid = 0;
    chk("busy_ld_err", 64'(err), 1);
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      if (done) begin seen = 1; break; end
      tick;
    end
    chk("busy_ld_done_seen", 64'(seen), 1);
    tick;
    run(2, d, b);
    chk_c("busy_ld_rerun", 19, 22, 43, 50);

    start = 1; k_len = 2;
    tick;
    start = 0;
    tick;
    tick;
    chk("pre_rst_a", 64'(a_raw), {32'd4, 32'd2});
    rst = 1;
    #1;
    chk("mid_rst_a", 64'(a_raw), 0);
    chk("mid_rst_w", 64'(w_raw), 0);
    chk("mid_rst_en", 64'({en_mult, en_accum, clr_mult, clr_accum}), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    tick;
    rst = 0;
    dn = 0;
    for (int n = 0; n < 12; n++) begin
      if (done) dn++;
      tick;
    end
    chk("abort_no_done", 64'(dn), 0);
    run(2, d, b);
    chk("cleared_done_at", 64'(d), 7);
    chk_c("cleared", 0, 0, 0, 0);
    load_s1;
    run(2, d, b);
    chk_c("reload", 19, 22, 43, 50);

    dn = 0; d1 = -1; d2 = -1;
    for (int n = 0; n < 20; n++) begin
      start = (n == 0 || n == 4 || n == 8);
      k_len = 2;
      if (n == 4) chk("b2b_busy_at4", 64'(busy), 1);
      if (done) begin
        dn++;
        if (d1 < 0) d1 = n; else d2 = n;
      end
      tick;
    end
    start = 0;
    chk("b2b_done_n", 64'(dn), 2);
    chk("b2b_done1", 64'(d1), 7);
    chk("b2b_done2", 64'(d2), 15);
    chk_c("b2b", 19, 22, 43, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
